// File: rtl/fixed_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_bcd_converter: sequential double-dabble, 16-bit word -> sign + BCD |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fixed_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [WIDTH-1:0]    shift_q;
  logic [BW-1:0]       scr_q;
  logic                sign_q;
  logic [BW-1:0]       bcd_q;
  logic                neg_q;
  logic [DIGITS-1:0]   blank_q;
  logic                busy_q;
  logic                done_q;

  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] cat;
  logic [BW-1:0]       scr_d;
  logic [WIDTH-1:0]    shift_d;
  logic [DIGITS-1:0]   blank_d;
  logic                sign_d;
  logic [WIDTH-1:0]    mag_d;
  logic                last;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_adj
      assign adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? (scr_q[4*g +: 4] + 4'd3)
                                                       : scr_q[4*g +: 4];
    end
  endgenerate

  assign cat = {adj, shift_q} << 1;
  assign {scr_d, shift_d} = cat;

  // Leading-zero mask is taken from the final scratch value being committed.
  generate
    for (g = 0; g < DIGITS; g++) begin : g_blank
      if (g == 0) begin : g_lsd
        assign blank_d[g] = 1'b0;
      end else begin : g_upper
        assign blank_d[g] = (scr_d[BW-1:4*g] == '0);
      end
    end
  endgenerate

  // Negation wraps in WIDTH bits, so the most negative input yields its unsigned magnitude.
  assign sign_d = (SIGNED != 0) && din[WIDTH-1];
  assign mag_d  = sign_d ? ((~din) + WIDTH'(1)) : din;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      scr_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_CONV;
            busy_q  <= 1'b1;
            shift_q <= mag_d;
            sign_q  <= sign_d;
            scr_q   <= '0;
            cnt_q   <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CONV: begin
          scr_q   <= scr_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            bcd_q   <= scr_d;
            neg_q   <= sign_q;
            blank_q <= blank_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign neg   = neg_q;
  assign blank = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_bcd_converter.sv
`default_nettype none
// Testbench for fixed_bcd_converter: signed and unsigned instances vs. an arithmetic model.
module tb_fixed_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s = 1'b0, start_u = 1'b0;
  logic [15:0] din_s = '0, din_u = '0;
  logic        busy_s, done_s, neg_s, busy_u, done_u, neg_u;
  logic [19:0] bcd_s, bcd_u;
  logic [4:0]  blank_s, blank_u;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fixed_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start_s), .din(din_s),
    .busy(busy_s), .done(done_s), .bcd(bcd_s), .neg(neg_s), .blank(blank_s)
  );

  fixed_bcd_converter #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .start(start_u), .din(din_u),
    .busy(busy_u), .done(done_u), .bcd(bcd_u), .neg(neg_u), .blank(blank_u)
  );

  // ---------------- reference model ----------------
  function automatic int m_mag(input logic [15:0] v, input bit sgn);
    if (sgn && v[15]) return 65536 - int'(v);
    return int'(v);
  endfunction

  function automatic logic [19:0] m_bcd(input logic [15:0] v, input bit sgn);
    logic [19:0] r;
    int mag = m_mag(v, sgn);
    int p = 1;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] m_blank(input logic [15:0] v, input bit sgn);
    logic [4:0] b;
    int mag = m_mag(v, sgn);
    int p = 10;
    b = '0;
    for (int i = 1; i < 5; i++) begin
      b[i] = (mag < p);
      p = p * 10;
    end
    return b;
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  task automatic conv(input bit uns, input logic [15:0] v, output int lat, output int bcnt);
    @(negedge clk);
    if (uns) begin start_u = 1'b1; din_u = v; end
    else     begin start_s = 1'b1; din_s = v; end
    @(negedge clk);
    start_u = 1'b0;
    start_s = 1'b0;
    lat  = 0;
    bcnt = (uns ? busy_u : busy_s) ? 1 : 0;
    while (!(uns ? done_u : done_s) && lat < 100) begin
      @(negedge clk);
      lat++;
      if (uns ? busy_u : busy_s) bcnt++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bcd_s !== 20'h0 || neg_s !== 1'b0) begin errors++;
      $display("FAIL reset_s_out bcd=%h neg=%b want 00000/0", bcd_s, neg_s); end
    checks++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin errors++;
      $display("FAIL reset_s_hs busy=%b done=%b want 0/0", busy_s, done_s); end
    checks++; if (blank_s !== 5'b11110) begin errors++;
      $display("FAIL reset_s_blank got=%b want 11110", blank_s); end
    checks++; if (bcd_u !== 20'h0 || blank_u !== 5'b11110 || busy_u !== 1'b0 || done_u !== 1'b0) begin errors++;
      $display("FAIL reset_u bcd=%h blank=%b busy=%b done=%b", bcd_u, blank_u, busy_u, done_u); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    bit          uns_t[7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [15:0] val_t[7] = '{16'h0000, 16'h3039, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0064, 16'h0000};
    int lat, bc;
    for (int i = 0; i < 7; i++) begin
      logic [19:0] gb;  logic gn;  logic [4:0] gk;
      bit sg = !uns_t[i];
      conv(uns_t[i], val_t[i], lat, bc);
      gb = uns_t[i] ? bcd_u : bcd_s;
      gn = uns_t[i] ? neg_u : neg_s;
      gk = uns_t[i] ? blank_u : blank_s;
      checks++; if (lat !== 16) begin errors++;
        $display("FAIL dir_latency din=%h got=%0d want 16", val_t[i], lat); end
      checks++; if (bc !== 16) begin errors++;
        $display("FAIL dir_busy_cycles din=%h got=%0d want 16", val_t[i], bc); end
      checks++; if (gb !== m_bcd(val_t[i], sg)) begin errors++;
        $display("FAIL dir_bcd din=%h uns=%0d got=%h want %h", val_t[i], uns_t[i], gb, m_bcd(val_t[i], sg)); end
      checks++; if (gn !== (sg && val_t[i][15])) begin errors++;
        $display("FAIL dir_neg din=%h got=%b want %b", val_t[i], gn, sg && val_t[i][15]); end
      checks++; if (gk !== m_blank(val_t[i], sg)) begin errors++;
        $display("FAIL dir_blank din=%h got=%b want %b", val_t[i], gk, m_blank(val_t[i], sg)); end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    for (int i = 0; i < 30; i++) begin
      logic [15:0] v = 16'($urandom);
      bit uns = (i % 3 == 2);
      bit sg = !uns;
      logic [19:0] gb;  logic gn;  logic [4:0] gk;
      conv(uns, v, lat, bc);
      gb = uns ? bcd_u : bcd_s;
      gn = uns ? neg_u : neg_s;
      gk = uns ? blank_u : blank_s;
      checks++; if (lat !== 16) begin errors++;
        $display("FAIL rnd_latency din=%h got=%0d want 16", v, lat); end
      checks++; if (gb !== m_bcd(v, sg) || gn !== (sg && v[15]) || gk !== m_blank(v, sg)) begin errors++;
        $display("FAIL rnd_result din=%h uns=%0d got=%h/%b/%b want %h/%b/%b", v, uns, gb, gn, gk,
                 m_bcd(v, sg), sg && v[15], m_blank(v, sg)); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] v = 16'h0457;
    int lat = 0;
    @(negedge clk); start_s = 1'b1; din_s = v;
    @(negedge clk); start_s = 1'b0;
    while (!done_s && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 3) begin start_s = 1'b1; din_s = 16'h0022; end
      if (lat == 4) start_s = 1'b0;
    end
    checks++; if (lat !== 16) begin errors++;
      $display("FAIL busy_start_latency got=%0d want 16", lat); end
    checks++; if (bcd_s !== m_bcd(v, 1'b1)) begin errors++;
      $display("FAIL busy_start_bcd got=%h want %h", bcd_s, m_bcd(v, 1'b1)); end
    repeat (5) @(negedge clk);
    checks++; if (bcd_s !== m_bcd(v, 1'b1) || done_s !== 1'b0 || busy_s !== 1'b0) begin errors++;
      $display("FAIL hold bcd=%h done=%b busy=%b want %h/0/0", bcd_s, done_s, busy_s, m_bcd(v, 1'b1)); end
  endtask

  task automatic test_abort();
    int lat, bc, ndone;
    conv(1'b0, 16'h0456, lat, bc);
    @(negedge clk); start_s = 1'b1; din_s = 16'h3039;
    @(negedge clk); start_s = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      if (j == 4) begin start_s = 1'b1; din_s = 16'h0001; end
      if (j == 5) start_s = 1'b0;
    end
    rst = 1'b1;
    #1;
    checks++; if (bcd_s !== 20'h0 || neg_s !== 1'b0 || blank_s !== 5'b11110) begin errors++;
      $display("FAIL abort_outputs bcd=%h neg=%b blank=%b want 00000/0/11110", bcd_s, neg_s, blank_s); end
    checks++; if (busy_s !== 1'b0 || done_s !== 1'b0) begin errors++;
      $display("FAIL abort_hs busy=%b done=%b want 0/0", busy_s, done_s); end
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    repeat (30) begin @(negedge clk); if (done_s) ndone++; end
    checks++; if (ndone !== 0) begin errors++;
      $display("FAIL abort_no_done got=%0d pulses want 0", ndone); end
    conv(1'b0, 16'h0007, lat, bc);
    checks++; if (lat !== 16 || bcd_s !== 20'h00007) begin errors++;
      $display("FAIL abort_restart lat=%0d bcd=%h want 16/00007", lat, bcd_s); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    int t = 0, last_t = -1, ndone = 0;
    @(negedge clk); start_s = 1'b1; din_s = 16'h0009;
    q.push_back(16'h0009);
    while (ndone < 4 && t < 120) begin
      @(negedge clk);
      t++;
      if (done_s) begin
        logic [15:0] e = q.pop_front();
        ndone++;
        checks++; if (bcd_s !== m_bcd(e, 1'b1)) begin errors++;
          $display("FAIL b2b_bcd pulse=%0d got=%h want %h", ndone, bcd_s, m_bcd(e, 1'b1)); end
        if (last_t >= 0) begin
          checks++; if (t - last_t !== 17) begin errors++;
            $display("FAIL b2b_period got=%0d want 17", t - last_t); end
        end
        last_t = t;
        q.push_back(din_s);
      end
      if (t == 25) din_s = 16'h0010;
    end
    start_s = 1'b0;
    checks++; if (ndone !== 4) begin errors++;
      $display("FAIL b2b_count got=%0d want 4", ndone); end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
